// File: rtl/wb_regfile_if.sv
// Write-back / decode-port bundle of the register file.
// The master drives the W-stage and read indices; the slave returns operands, counters and trace.
interface wb_regfile_if;
  logic        RegWrite_w;
  logic [1:0]  ResultSrc_w;
  logic [31:0] ALUResult_w;
  logic [31:0] ReadData_w;
  logic [31:0] pcplus4_w;
  logic [31:0] pc_w;
  logic [4:0]  rd_w;
  logic        valid_w;
  logic [4:0]  rs1_d;
  logic [4:0]  rs2_d;
  logic [31:0] rd1_d;
  logic [31:0] rd2_d;
  logic [31:0] Result_w;
  logic [63:0] instret;
  logic [63:0] mcycle;
  logic        trace_valid;
  logic [31:0] trace_pc;
  logic [31:0] trace_wdata;
  logic [4:0]  trace_rd;

  modport master (
    output RegWrite_w, ResultSrc_w, ALUResult_w, ReadData_w, pcplus4_w, pc_w, rd_w, valid_w,
    output rs1_d, rs2_d,
    input  rd1_d, rd2_d, Result_w, instret, mcycle,
    input  trace_valid, trace_pc, trace_wdata, trace_rd
  );

  modport slave (
    input  RegWrite_w, ResultSrc_w, ALUResult_w, ReadData_w, pcplus4_w, pc_w, rd_w, valid_w,
    input  rs1_d, rs2_d,
    output rd1_d, rd2_d, Result_w, instret, mcycle,
    output trace_valid, trace_pc, trace_wdata, trace_rd
  );
endinterface

// File: rtl/wb_regfile.sv
// RV32 integer register file with write-back mux, write-through bypass,
// retire/cycle counters and a registered retire trace port.
module wb_regfile (
  input  logic         clk,
  input  logic         rst_n,
  wb_regfile_if.slave  bus
);

  localparam logic [31:0] BUBBLE_PC = 32'hFFFF_FFFF;

  logic [31:0] r_regs [1:31];
  logic [63:0] r_instret;
  logic [63:0] r_mcycle;
  logic        r_trace_valid;
  logic [31:0] r_trace_pc;
  logic [31:0] r_trace_wdata;
  logic [4:0]  r_trace_rd;

  logic [31:0] w_result;
  logic        w_retire;
  logic        w_write;
  logic [31:0] w_rd1;
  logic [31:0] w_rd2;

  // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
  always_comb begin
    w_result = bus.ALUResult_w;
    case (bus.ResultSrc_w)
      2'b01:   w_result = bus.ReadData_w;
      2'b10:   w_result = bus.pcplus4_w;
      default: w_result = bus.ALUResult_w;
    endcase
  end

  assign w_retire = bus.valid_w && (bus.pc_w != BUBBLE_PC);
  // Gated by rst_n so the bypass is dead while the array is being cleared.
  assign w_write  = rst_n && w_retire && bus.RegWrite_w && (bus.rd_w != 5'd0);

  always_comb begin
    w_rd1 = 32'd0;
    if (bus.rs1_d != 5'd0) begin
      if (w_write && (bus.rd_w == bus.rs1_d)) w_rd1 = w_result;
      else                                    w_rd1 = r_regs[bus.rs1_d];
    end
  end

  always_comb begin
    w_rd2 = 32'd0;
    if (bus.rs2_d != 5'd0) begin
      if (w_write && (bus.rd_w == bus.rs2_d)) w_rd2 = w_result;
      else                                    w_rd2 = r_regs[bus.rs2_d];
    end
  end

  // NOTE: sequential state uses non-blocking assignments only, so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      // NOTE: the array is reset explicitly because architectural state must read zero after reset.
      for (int i = 1; i < 32; i++) r_regs[i] <= 32'd0;
      r_instret     <= 64'd0;
      r_mcycle      <= 64'd0;
      r_trace_valid <= 1'b0;
      r_trace_pc    <= 32'd0;
      r_trace_wdata <= 32'd0;
      r_trace_rd    <= 5'd0;
    end else begin
      r_mcycle      <= r_mcycle + 64'd1;
      r_trace_valid <= w_retire;
      if (w_write) r_regs[bus.rd_w] <= w_result;
      if (w_retire) begin
        r_instret     <= r_instret + 64'd1;
        r_trace_pc    <= bus.pc_w;
        r_trace_wdata <= w_result;
        r_trace_rd    <= bus.RegWrite_w ? bus.rd_w : 5'd0;
      end
    end
  end

  assign bus.Result_w    = w_result;
  assign bus.rd1_d       = w_rd1;
  assign bus.rd2_d       = w_rd2;
  assign bus.instret     = r_instret;
  assign bus.mcycle      = r_mcycle;
  assign bus.trace_valid = r_trace_valid;
  assign bus.trace_pc    = r_trace_pc;
  assign bus.trace_wdata = r_trace_wdata;
  assign bus.trace_rd    = r_trace_rd;

endmodule

// File: tb/tb_wb_regfile.sv
// Directed bench for wb_regfile: vector table for the W/D stage function,
// hand-written sequences for reset priority, mcycle start and instret wrap.
module tb_wb_regfile;

  logic clk;
  logic rst_n;
  wb_regfile_if bus ();

  wb_regfile dut (.clk(clk), .rst_n(rst_n), .bus(bus));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_cmp  = 0;
  int n_fail = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  typedef struct packed {
    logic        rw;
    logic [1:0]  src;
    logic [31:0] alu;
    logic [31:0] rdata;
    logic [31:0] p4;
    logic [31:0] pc;
    logic [4:0]  rd;
    logic        valid;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [31:0] e_res;
    logic [31:0] e_rd1;
    logic [31:0] e_rd2;
    logic        e_tv;
    logic [31:0] e_tpc;
    logic [31:0] e_twd;
    logic [4:0]  e_trd;
    logic [63:0] e_instret;
  } vec_t;

  localparam int NVEC = 14;
  vec_t vecs [NVEC];

  task automatic drive(input logic rw, input logic [1:0] src, input logic [31:0] alu,
                       input logic [31:0] pc, input logic [4:0] rd, input logic valid,
                       input logic [4:0] rs1, input logic [4:0] rs2);
    bus.RegWrite_w  = rw;
    bus.ResultSrc_w = src;
    bus.ALUResult_w = alu;
    bus.ReadData_w  = 32'd0;
    bus.pcplus4_w   = 32'd0;
    bus.pc_w        = pc;
    bus.rd_w        = rd;
    bus.valid_w     = valid;
    bus.rs1_d       = rs1;
    bus.rs2_d       = rs2;
  endtask

  initial begin
    //            rw src  alu           rdata         p4            pc            rd valid rs1 rs2 e_res         e_rd1         e_rd2         tv tpc           twd           trd instret
    vecs[0]  = '{1'b1, 2'b01, 32'h0,        32'hDEADBEEF, 32'h0,   32'h100,      5'd5, 1'b1, 5'd5, 5'd0, 32'hDEADBEEF, 32'hDEADBEEF, 32'h0,        1'b1, 32'h100, 32'hDEADBEEF, 5'd5, 64'd1};
    vecs[1]  = '{1'b0, 2'b00, 32'h11,       32'h0,        32'h0,   32'h0,        5'd0, 1'b0, 5'd5, 5'd5, 32'h11,       32'hDEADBEEF, 32'hDEADBEEF, 1'b0, 32'h100, 32'hDEADBEEF, 5'd5, 64'd1};
    vecs[2]  = '{1'b1, 2'b00, 32'h1234,     32'h0,        32'h0,   32'h104,      5'd0, 1'b1, 5'd0, 5'd0, 32'h1234,     32'h0,        32'h0,        1'b1, 32'h104, 32'h1234,     5'd0, 64'd2};
    vecs[3]  = '{1'b0, 2'b11, 32'h5555,     32'h0,        32'h0,   32'h0,        5'd0, 1'b0, 5'd0, 5'd0, 32'h5555,     32'h0,        32'h0,        1'b0, 32'h104, 32'h1234,     5'd0, 64'd2};
    vecs[4]  = '{1'b1, 2'b00, 32'h77,       32'h0,        32'h0,   32'h108,      5'd7, 1'b1, 5'd7, 5'd5, 32'h77,       32'h77,       32'hDEADBEEF, 1'b1, 32'h108, 32'h77,       5'd7, 64'd3};
    vecs[5]  = '{1'b1, 2'b00, 32'h99,       32'h0,        32'h0,   32'hFFFFFFFF, 5'd7, 1'b1, 5'd7, 5'd7, 32'h99,       32'h77,       32'h77,       1'b0, 32'h108, 32'h77,       5'd7, 64'd3};
    vecs[6]  = '{1'b0, 2'b00, 32'h0,        32'h0,        32'h0,   32'h0,        5'd0, 1'b0, 5'd7, 5'd0, 32'h0,        32'h77,       32'h0,        1'b0, 32'h108, 32'h77,       5'd7, 64'd3};
    vecs[7]  = '{1'b1, 2'b10, 32'h1,        32'h2,        32'h204, 32'h200,      5'd1, 1'b1, 5'd0, 5'd1, 32'h204,      32'h0,        32'h204,      1'b1, 32'h200, 32'h204,      5'd1, 64'd4};
    vecs[8]  = '{1'b0, 2'b01, 32'h0,        32'h3,        32'h0,   32'h0,        5'd0, 1'b0, 5'd1, 5'd1, 32'h3,        32'h204,      32'h204,      1'b0, 32'h200, 32'h204,      5'd1, 64'd4};
    vecs[9]  = '{1'b0, 2'b11, 32'hCAFE,     32'h0,        32'h0,   32'h20C,      5'd9, 1'b1, 5'd9, 5'd0, 32'hCAFE,     32'h0,        32'h0,        1'b1, 32'h20C, 32'hCAFE,     5'd0, 64'd5};
    vecs[10] = '{1'b1, 2'b00, 32'hBEEF,     32'h0,        32'h0,   32'h210,      5'd9, 1'b0, 5'd9, 5'd0, 32'hBEEF,     32'h0,        32'h0,        1'b0, 32'h20C, 32'hCAFE,     5'd0, 64'd5};
    vecs[11] = '{1'b0, 2'b00, 32'h0,        32'h0,        32'h0,   32'h0,        5'd0, 1'b0, 5'd9, 5'd7, 32'h0,        32'h0,        32'h77,       1'b0, 32'h20C, 32'hCAFE,     5'd0, 64'd5};
    vecs[12] = '{1'b1, 2'b11, 32'h5A5A,     32'h0,        32'h0,   32'h214,      5'd5, 1'b1, 5'd5, 5'd5, 32'h5A5A,     32'h5A5A,     32'h5A5A,     1'b1, 32'h214, 32'h5A5A,     5'd5, 64'd6};
    vecs[13] = '{1'b0, 2'b00, 32'h0,        32'h0,        32'h0,   32'h0,        5'd0, 1'b0, 5'd5, 5'd1, 32'h0,        32'h5A5A,     32'h204,      1'b0, 32'h214, 32'h5A5A,     5'd5, 64'd6};

    // Reset held two cycles with idle inputs.
    rst_n = 1'b0;
    drive(1'b0, 2'b00, 32'h0, 32'h0, 5'd0, 1'b0, 5'd0, 5'd0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("reset_instret", bus.instret, 64'd0);
    check("reset_mcycle", bus.mcycle, 64'd0);
    check("reset_trace_valid", {63'd0, bus.trace_valid}, 64'd0);
    check("reset_trace_pc", {32'd0, bus.trace_pc}, 64'd0);

    // A write to x3 during reset must be lost and must not bypass.
    drive(1'b1, 2'b00, 32'hAAAA, 32'h40, 5'd3, 1'b1, 5'd3, 5'd3);
    #1;
    check("rst_no_bypass_rd1", {32'd0, bus.rd1_d}, 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    drive(1'b0, 2'b00, 32'h0, 32'h0, 5'd0, 1'b0, 5'd3, 5'd0);
    #1;
    check("rst_x3_lost", {32'd0, bus.rd1_d}, 64'd0);
    check("rst_write_no_trace", {63'd0, bus.trace_valid}, 64'd0);
    check("rst_write_no_retire", bus.instret, 64'd0);
    for (int k = 1; k <= 3; k++) begin
      @(negedge clk);
      check($sformatf("mcycle_%0d", k), bus.mcycle, 64'(k));
    end

    // Table: combinational outputs before the edge, registered outputs after it.
    for (int i = 0; i < NVEC; i++) begin
      drive(vecs[i].rw, vecs[i].src, vecs[i].alu, vecs[i].pc, vecs[i].rd, vecs[i].valid,
            vecs[i].rs1, vecs[i].rs2);
      bus.ReadData_w = vecs[i].rdata;
      bus.pcplus4_w  = vecs[i].p4;
      #1;
      check($sformatf("v%0d_result", i), {32'd0, bus.Result_w}, {32'd0, vecs[i].e_res});
      check($sformatf("v%0d_rd1", i), {32'd0, bus.rd1_d}, {32'd0, vecs[i].e_rd1});
      check($sformatf("v%0d_rd2", i), {32'd0, bus.rd2_d}, {32'd0, vecs[i].e_rd2});
      @(negedge clk);
      check($sformatf("v%0d_trace_valid", i), {63'd0, bus.trace_valid}, {63'd0, vecs[i].e_tv});
      check($sformatf("v%0d_trace_pc", i), {32'd0, bus.trace_pc}, {32'd0, vecs[i].e_tpc});
      check($sformatf("v%0d_trace_wdata", i), {32'd0, bus.trace_wdata}, {32'd0, vecs[i].e_twd});
      check($sformatf("v%0d_trace_rd", i), {59'd0, bus.trace_rd}, {59'd0, vecs[i].e_trd});
      check($sformatf("v%0d_instret", i), bus.instret, vecs[i].e_instret);
      check($sformatf("v%0d_mcycle", i), bus.mcycle, 64'(4 + i));
    end

    // instret wrap: preload all-ones, retire one instruction.
    force dut.r_instret = 64'hFFFF_FFFF_FFFF_FFFF;
    #1;
    release dut.r_instret;
    drive(1'b0, 2'b00, 32'h0, 32'h300, 5'd0, 1'b1, 5'd0, 5'd0);
    @(negedge clk);
    check("wrap_instret", bus.instret, 64'd0);
    check("wrap_trace_valid", {63'd0, bus.trace_valid}, 64'd1);
    check("wrap_trace_pc", {32'd0, bus.trace_pc}, 64'h300);

    // Reset wins over a simultaneous write/retire; x5 and counters clear.
    rst_n = 1'b0;
    drive(1'b1, 2'b00, 32'h1111, 32'h400, 5'd5, 1'b1, 5'd5, 5'd5);
    @(negedge clk);
    rst_n = 1'b1;
    drive(1'b0, 2'b00, 32'h0, 32'h0, 5'd0, 1'b0, 5'd5, 5'd1);
    #1;
    check("rst2_x5", {32'd0, bus.rd1_d}, 64'd0);
    check("rst2_x1", {32'd0, bus.rd2_d}, 64'd0);
    check("rst2_instret", bus.instret, 64'd0);
    check("rst2_trace_valid", {63'd0, bus.trace_valid}, 64'd0);
    check("rst2_trace_wdata", {32'd0, bus.trace_wdata}, 64'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/wb_regfile.md
WB_REGFILE -- requirements
Module: wb_regfile

Interface
REQ-001 clk  in  1  single clock; all state updates on posedge clk.
REQ-002 rst_n  in  1  reset, synchronous, active-low.
REQ-003 RegWrite_w  in  1  W-stage register write enable.
REQ-004 ResultSrc_w  in  2  result select: 00 ALUResult_w, 01 ReadData_w, 10 pcplus4_w, 11 ALUResult_w.
REQ-005 ALUResult_w, ReadData_w, pcplus4_w, pc_w  in  32 each  W-stage data; pc_w = 32'hFFFFFFFF marks a flushed bubble.
REQ-006 rd_w  in  5  destination register index.
REQ-007 valid_w  in  1  W stage holds a new instruction this cycle; high for exactly one cycle per instruction.
REQ-008 rs1_d, rs2_d  in  5 each  decode-stage source indices.
REQ-009 rd1_d, rd2_d  out  32 each  decode-stage operand data.
REQ-010 Result_w  out  32  selected write-back value.
REQ-011 instret  out  64  retired-instruction counter.
REQ-012 mcycle  out  64  cycle counter.
REQ-013 trace_valid  out  1  registered retire strobe.
REQ-014 trace_pc, trace_wdata  out  32 each  registered retire PC and write data.
REQ-015 trace_rd  out  5  registered retire destination (0 if no write).

Function
REQ-016 Result_w SHALL be combinational from ResultSrc_w per REQ-004.
REQ-017 Storage SHALL be 31 x 32-bit registers x1..x31; x0 SHALL read 0 always and never be written.
REQ-018 Write SHALL occur at posedge when rst_n=1, RegWrite_w=1, rd_w!=0, valid_w=1, pc_w!=32'hFFFFFFFF: reg[rd_w] <= Result_w.
REQ-019 Reads SHALL be combinational: rdN_d = 0 if rsN_d=0; else Result_w if a write per REQ-018 is pending this cycle with rd_w=rsN_d (write-through bypass); else reg[rsN_d].
REQ-020 Both read ports SHALL be independent; rs1_d=rs2_d SHALL return identical data on both.
REQ-021 Retire condition SHALL be valid_w=1 and pc_w!=32'hFFFFFFFF, independent of RegWrite_w.
REQ-022 instret SHALL increment by 1 at each posedge with retire condition true; wraps 2^64-1 -> 0.
REQ-023 mcycle SHALL increment by 1 every posedge with rst_n=1; wraps 2^64-1 -> 0.
REQ-024 Trace outputs SHALL be registered, 1-cycle latency: trace_valid <= retire condition; when retiring, trace_pc <= pc_w, trace_wdata <= Result_w, trace_rd <= (RegWrite_w ? rd_w : 0); otherwise trace_pc/trace_rd/trace_wdata hold their previous values.
REQ-025 Bubble (pc_w=32'hFFFFFFFF) with RegWrite_w=1 SHALL neither write nor retire.
REQ-026 valid_w=0 SHALL suppress write, retire, and trace regardless of other inputs.

Reset
REQ-027 While rst_n=0 at posedge: x1..x31 <= 0, instret <= 0, mcycle <= 0, trace_valid <= 0, trace_pc <= 0, trace_wdata <= 0, trace_rd <= 0.
REQ-028 Reset SHALL take priority over a simultaneous write or retire; that write SHALL be lost.
REQ-029 Bypass per REQ-019 SHALL be inactive while rst_n=0; reads return stored (zero) values.

Verification
REQ-030 Reset, then ResultSrc_w=01, ReadData_w=32'hDEADBEEF, rd_w=5, RegWrite_w=1, valid_w=1, pc_w=32'h100, rs1_d=5 -> same-cycle rd1_d=32'hDEADBEEF; next cycle trace_valid=1, trace_pc=32'h100, trace_rd=5, instret=1.
REQ-031 Write rd_w=0, ALUResult_w=32'h1234, ResultSrc_w=00, rs1_d=rs2_d=0 -> rd1_d=rd2_d=0 same and following cycles; trace_rd=0; instret increments.
REQ-032 pc_w=32'hFFFFFFFF, RegWrite_w=1, rd_w=7, valid_w=1 -> x7 unchanged, instret unchanged, trace_valid=0 next cycle.
REQ-033 ResultSrc_w=10, pcplus4_w=32'h204, rd_w=1 (JAL link) -> x1=32'h204 next cycle; rs2_d=1 reads 32'h204.
REQ-034 Write x3 with valid_w=1 while rst_n=0 -> x3=0 after reset released; mcycle counts 1,2,3 on subsequent cycles.
REQ-035 Force instret=64'hFFFFFFFF_FFFFFFFF, retire one instruction -> instret=0, trace_valid=1.
